duty_meter: RTL and testbench
=============================

DUTY_METER -- requirements
Module: duty_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000000: minimum measurement window in clk cycles (1 s at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000000: maximum clk cycles without a required rising edge before the block aborts.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sig  input  1  raw measured signal, asynchronous to clk.
REQ-006 SHALL have port high_cnt  input  32  free-running high-time counter from the upstream stage; increments by one per clk while its synchronised sig is 1.
REQ-007 SHALL have port start  input  1  single-cycle request to begin one measurement.
REQ-008 SHALL have port ack  input  1  reader acknowledges the result.
REQ-009 SHALL have port busy  output  1  measurement in progress.
REQ-010 SHALL have port valid  output  1  result registers hold a finished measurement.
REQ-011 SHALL have port timeout  output  1  the finished measurement was aborted.
REQ-012 SHALL have port period_ticks  output  32  clk cycles between the opening and closing rising edges.
REQ-013 SHALL have port high_ticks  output  32  high-time cycles within the same interval.
REQ-014 SHALL have port edges  output  32  number of whole sig periods in the interval.

Function
REQ-015 SHALL synchronise sig through two flops (s1, s2) plus a history flop s3; rise = s2 & ~s3.
REQ-016 SHALL implement states IDLE, ARM, MEAS and DONE.
REQ-017 IDLE: SHALL go to ARM when start=1 and clear the timer.
REQ-018 ARM: on rise, SHALL snapshot h0 = high_cnt, clear the period timer and edge count, and go to MEAS.
REQ-019 ARM: if TIMEOUT_CYCLES cycles pass without a rise, SHALL go to DONE with timeout=1 and all three results = 0.
REQ-020 MEAS: SHALL count each rise in edges. The first rise at least GATE_CYCLES cycles after the opening rise SHALL close the window.
REQ-021 On close, SHALL set period_ticks = cycles from the opening rise to the closing rise.
REQ-022 On close, SHALL set high_ticks = high_cnt - h0, modulo 2^32 (wrap-safe), and go to DONE.
REQ-023 MEAS: if TIMEOUT_CYCLES cycles pass after the opening rise without a close, SHALL go to DONE with timeout=1 and results = 0.
REQ-024 DONE: valid=1 and the results SHALL stay constant. ack=1 SHALL return to IDLE; ack=1 together with start=1 SHALL go directly to ARM.
REQ-025 start SHALL be ignored in ARM, MEAS and DONE unless accompanied by ack in DONE.
REQ-026 busy SHALL be 1 exactly in ARM and MEAS. valid SHALL be 1 exactly in DONE.
REQ-027 Internal counters SHALL saturate at all-ones rather than wrap.
REQ-028 Result registers SHALL update only on the DONE entry cycle.

Reset
REQ-029 reset=0 SHALL force the state to IDLE, clear s1/s2/s3, h0, the timer and edges, and drive busy=valid=timeout=0 and period_ticks=high_ticks=edges=0.
REQ-030 Assertion of reset in any state, including mid-MEAS, SHALL abandon the measurement with no partial result visible.

Structure
REQ-031 A shared package SHALL hold the state encoding and the 32-bit count width constant.
REQ-032 The edge detector (sync + rise) SHALL be sub-module sig_edge_sync, which is reusable by sibling frequency blocks.

Verification
REQ-033 Stimulus: GATE_CYCLES=25; sig period 10 clk with 3 clk high; bench model of the upstream counter; start pulse. Required: valid with period_ticks=30, edges=3, high_ticks=9, timeout=0.
REQ-034 Stimulus: same as REQ-033, with the counter model preloaded to 0xFFFFFFF8. Required: high_ticks=9 across the wrap.
REQ-035 Stimulus: TIMEOUT_CYCLES=100; sig held at 0; start pulse. Required: valid and timeout=1 about 100 cycles after start, with all results 0.
REQ-036 Stimulus: reset pulsed mid-MEAS. Required: all outputs 0, busy=0; a following start completes with correct results.
REQ-037 Stimulus: ack and start asserted in the same DONE cycle. Required: valid drops next cycle, busy=1, and a new result follows.
REQ-038 Stimulus: start pulsed during MEAS. Required: no effect on the results.

Source files
------------

// File: rtl/duty_meter_pkg.sv
// rtl/duty_meter_pkg.sv - shared state encoding, count width and saturating increment for duty_meter
package duty_meter_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// rtl/sig_edge_sync.sv - two-flop synchroniser plus history flop; single-cycle rise strobe
module sig_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/duty_meter.sv
// rtl/duty_meter.sv - gated period / high-time / edge-count measurement of an asynchronous signal
module duty_meter
    import duty_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES    = 50000000,
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig,
    input  logic [CNT_W-1:0] high_cnt,
    input  logic             start,
    input  logic             ack,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] period_ticks,
    output logic [CNT_W-1:0] high_ticks,
    output logic [CNT_W-1:0] edges
);

    // timer holds (cycles elapsed - 1), so thresholds compare against N-1
    localparam logic [CNT_W-1:0] GATE_LAST    = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic             rise;
    logic             close;
    logic             abort;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] h0;

    sig_edge_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .sig   (sig),
        .rise  (rise)
    );

    assign close = (state == MEAS) && rise && (timer >= GATE_LAST);
    assign abort = ((state == ARM && !rise) || (state == MEAS && !close))
                   && (timer >= TIMEOUT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            timer    <= '0;
            edge_cnt <= '0;
            h0       <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARM;
                        timer <= '0;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (rise) begin
                        state    <= MEAS;
                        h0       <= high_cnt;
                        timer    <= '0;
                        edge_cnt <= '0;
                    end else if (abort) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end
                MEAS: begin
                    if (close || abort) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                    end else begin
                        timer <= sat_inc(timer);
                        if (rise) edge_cnt <= sat_inc(edge_cnt);
                    end
                end
                DONE: begin
                    if (ack) begin
                        valid <= 1'b0;
                        if (start) begin
                            state <= ARM;
                            timer <= '0;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Results load only on the cycle that enters DONE and are otherwise frozen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_ticks <= '0;
            high_ticks   <= '0;
            edges        <= '0;
            timeout      <= 1'b0;
        end else if (close) begin
            period_ticks <= sat_inc(timer);
            high_ticks   <= high_cnt - h0;
            edges        <= sat_inc(edge_cnt);
            timeout      <= 1'b0;
        end else if (abort) begin
            period_ticks <= '0;
            high_ticks   <= '0;
            edges        <= '0;
            timeout      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_duty_meter.sv
// tb/tb_duty_meter.sv - randomized self-checking bench for duty_meter
module tb_duty_meter;

    localparam int GATE = 25;
    localparam int TMO  = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sig = 1'b0;
    logic [31:0] high_cnt = 32'd0;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic        busy, valid, timeout;
    logic [31:0] period_ticks, high_ticks, edges;

    int checks = 0;
    int errors = 0;

    bit          gen_on = 1'b0;
    int          gen_period = 10;
    int          gen_high = 3;
    int          phase = 0;
    logic        up_s1 = 1'b0, up_s2 = 1'b0;
    logic        cnt_load = 1'b0;
    logic [31:0] cnt_preset = 32'd0;

    int exp_p, exp_e, exp_h, cyc;

    duty_meter #(.GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .sig          (sig),
        .high_cnt     (high_cnt),
        .start        (start),
        .ack          (ack),
        .busy         (busy),
        .valid        (valid),
        .timeout      (timeout),
        .period_ticks (period_ticks),
        .high_ticks   (high_ticks),
        .edges        (edges)
    );

    always #5 clk = ~clk;

    // Periodic signal source, changing shortly after the clock edge
    always @(posedge clk) begin
        #2;
        if (gen_on) begin
            sig = (phase < gen_high);
            phase = (phase + 1 >= gen_period) ? 0 : phase + 1;
        end else begin
            sig = 1'b0;
            phase = 0;
        end
    end

    // Upstream high-time counter: its own synchroniser, +1 per clk while high
    always @(posedge clk) begin
        up_s1 <= sig;
        up_s2 <= up_s1;
        if (cnt_load) high_cnt <= cnt_preset;
        else if (up_s2) high_cnt <= high_cnt + 32'd1;
    end

    // Reference: window closes on the first whole period reaching the gate
    task automatic model(input int p, input int h);
        exp_e = (GATE + p - 1) / p;
        exp_p = exp_e * p;
        exp_h = exp_e * h;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk) ack = 1'b1;
        @(negedge clk) ack = 1'b0;
    endtask

    task automatic load_cnt(input logic [31:0] v);
        @(negedge clk) begin cnt_preset = v; cnt_load = 1'b1; end
        @(negedge clk) cnt_load = 1'b0;
    endtask

    task automatic set_gen(input int p, input int h);
        @(negedge clk) gen_on = 1'b0;
        @(negedge clk) begin gen_period = p; gen_high = h; gen_on = 1'b1; end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (valid !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        cycles(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b expected 0", timeout); end
        checks++; if (period_ticks !== 32'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period_ticks); end
        checks++; if (high_ticks !== 32'd0) begin errors++; $display("FAIL reset_high: got %0d expected 0", high_ticks); end
        checks++; if (edges !== 32'd0) begin errors++; $display("FAIL reset_edges: got %0d expected 0", edges); end
        @(negedge clk) reset = 1'b1;
        cycles(2);
    endtask

    task automatic test_basic(input logic [31:0] preset, input string tag);
        load_cnt(preset);
        set_gen(10, 3);
        model(10, 3);
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %0b expected 1", tag, busy); end
        wait_valid(cyc);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %0b expected 1", tag, valid); end
        checks++; if (period_ticks !== 32'(exp_p)) begin errors++; $display("FAIL %s_period: got %0d expected %0d", tag, period_ticks, exp_p); end
        checks++; if (edges !== 32'(exp_e)) begin errors++; $display("FAIL %s_edges: got %0d expected %0d", tag, edges, exp_e); end
        checks++; if (high_ticks !== 32'(exp_h)) begin errors++; $display("FAIL %s_high: got %0d expected %0d", tag, high_ticks, exp_h); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL %s_timeout: got %0b expected 0", tag, timeout); end
        cycles(4);
        checks++; if (period_ticks !== 32'(exp_p) || valid !== 1'b1) begin errors++; $display("FAIL %s_hold: got %0d/%0b expected %0d/1", tag, period_ticks, valid, exp_p); end
        do_ack();
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_idle: got valid %0b busy %0b expected 0 0", tag, valid, busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            int p, h;
            p = $urandom_range(13, 4);
            h = $urandom_range(p - 1, 1);
            load_cnt($urandom);
            set_gen(p, h);
            model(p, h);
            cycles($urandom_range(20, 0));
            pulse_start();
            wait_valid(cyc);
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rand%0d_valid: got %0b expected 1", i, valid); end
            checks++; if (period_ticks !== 32'(exp_p)) begin errors++; $display("FAIL rand%0d_period: got %0d expected %0d (p=%0d h=%0d)", i, period_ticks, exp_p, p, h); end
            checks++; if (edges !== 32'(exp_e)) begin errors++; $display("FAIL rand%0d_edges: got %0d expected %0d", i, edges, exp_e); end
            checks++; if (high_ticks !== 32'(exp_h)) begin errors++; $display("FAIL rand%0d_high: got %0d expected %0d", i, high_ticks, exp_h); end
            do_ack();
        end
    endtask

    task automatic test_timeout();
        @(negedge clk) gen_on = 1'b0;
        cycles(5);
        pulse_start();
        wait_valid(cyc);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL tmo_valid: got %0b expected 1", valid); end
        checks++; if (cyc < TMO - 5 || cyc > TMO + 5) begin errors++; $display("FAIL tmo_latency: got %0d expected about %0d", cyc, TMO); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %0b expected 1", timeout); end
        checks++; if (period_ticks !== 0 || high_ticks !== 0 || edges !== 0) begin errors++; $display("FAIL tmo_results: got %0d/%0d/%0d expected 0/0/0", period_ticks, high_ticks, edges); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %0b expected 0", busy); end
        do_ack();
    endtask

    task automatic test_reset_mid();
        set_gen(10, 3);
        model(10, 3);
        pulse_start();
        cycles(20);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %0b expected 1", busy); end
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 0 || valid !== 0 || timeout !== 0) begin errors++; $display("FAIL rmid_flags: got %0b%0b%0b expected 000", busy, valid, timeout); end
        checks++; if (period_ticks !== 0 || high_ticks !== 0 || edges !== 0) begin errors++; $display("FAIL rmid_results: got %0d/%0d/%0d expected 0/0/0", period_ticks, high_ticks, edges); end
        @(negedge clk) reset = 1'b1;
        cycles(2);
        pulse_start();
        wait_valid(cyc);
        checks++; if (valid !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL rmid_after_valid: got %0b/%0b expected 1/0", valid, timeout); end
        checks++; if (period_ticks !== 32'(exp_p) || edges !== 32'(exp_e) || high_ticks !== 32'(exp_h)) begin errors++; $display("FAIL rmid_after_results: got %0d/%0d/%0d expected %0d/%0d/%0d", period_ticks, edges, high_ticks, exp_p, exp_e, exp_h); end
        do_ack();
    endtask

    task automatic test_back_to_back();
        set_gen(7, 2);
        model(7, 2);
        pulse_start();
        wait_valid(cyc);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid: got %0b expected 1", valid); end
        ack = 1'b1;
        start = 1'b1;
        @(negedge clk) begin ack = 1'b0; start = 1'b0; end
        checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_rearm: got valid %0b busy %0b expected 0 1", valid, busy); end
        wait_valid(cyc);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %0b expected 1", valid); end
        checks++; if (period_ticks !== 32'(exp_p) || edges !== 32'(exp_e) || high_ticks !== 32'(exp_h)) begin errors++; $display("FAIL b2b_results: got %0d/%0d/%0d expected %0d/%0d/%0d", period_ticks, edges, high_ticks, exp_p, exp_e, exp_h); end
        do_ack();
    endtask

    task automatic test_start_in_meas();
        set_gen(6, 4);
        model(6, 4);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            cycles(5);
            pulse_start();
        end
        wait_valid(cyc);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL smeas_valid: got %0b expected 1", valid); end
        checks++; if (period_ticks !== 32'(exp_p) || edges !== 32'(exp_e) || high_ticks !== 32'(exp_h)) begin errors++; $display("FAIL smeas_results: got %0d/%0d/%0d expected %0d/%0d/%0d", period_ticks, edges, high_ticks, exp_p, exp_e, exp_h); end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_basic(32'd100, "basic");
        test_basic(32'hFFFF_FFF8, "wrap");
        test_random();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_start_in_meas();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
